aes_decrypt_core: RTL and testbench

Iterative AES-128 decryption core; the inverse-direction counterpart to the encryption datapath built on the shared `aes_model_pack` tables and GF(2^8) helpers. It accepts one 128-bit ciphertext block over a valid/ready handshake and applies the inverse cipher using an externally expanded key schedule. It returns the plaintext over a second valid/ready handshake. It sits behind the Avalon enforcer/stream front end, with one block in flight at a time.

---
 rtl/aes_decrypt_core.sv | 134 +++++++++++++
 tb/tb_aes_decrypt_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 inverse cipher, one block in flight.
// Ciphertext is accepted over in_valid/in_ready, and plaintext is returned over out_valid/out_ready.
// Byte i of in_data, out_data and of every key_schedule entry (bits [8i+7:8i])
// is state row i%4, column i/4. FIPS byte 0 is byte 0.
// Optional build macro AES_DEC_UNROLL2_EN: two inverse rounds per ROUND cycle.
module aes_decrypt_core (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0][127:0] key_schedule,
  input  logic [15:0][7:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [15:0][7:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

  localparam logic [7:0] INV_SUB_BYTES_TABLE [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant k as a sum of b, 2b, 4b, 8b.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction

  // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
  function automatic logic [15:0][7:0] inv_round(input logic [15:0][7:0] s,
                                                 input logic [127:0] rk,
                                                 input logic mix);
    logic [15:0][7:0] t, u;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = INV_SUB_BYTES_TABLE[s[r+4*((c-r+4)%4)]] ^ rk[8*(r+4*c) +: 8];
    u = t;
    if (mix)
      for (int c = 0; c < 4; c++) begin
        u[4*c]   = gmul(t[4*c],4'he) ^ gmul(t[4*c+1],4'hb) ^ gmul(t[4*c+2],4'hd) ^ gmul(t[4*c+3],4'h9);
        u[4*c+1] = gmul(t[4*c],4'h9) ^ gmul(t[4*c+1],4'he) ^ gmul(t[4*c+2],4'hb) ^ gmul(t[4*c+3],4'hd);
        u[4*c+2] = gmul(t[4*c],4'hd) ^ gmul(t[4*c+1],4'h9) ^ gmul(t[4*c+2],4'he) ^ gmul(t[4*c+3],4'hb);
        u[4*c+3] = gmul(t[4*c],4'hb) ^ gmul(t[4*c+1],4'hd) ^ gmul(t[4*c+2],4'h9) ^ gmul(t[4*c+3],4'he);
      end
    return u;
  endfunction

  state_e           st_q, st_d;
  logic [15:0][7:0] blk_q, blk_d;
  logic [3:0]       rnd_q, rnd_d;

`ifdef AES_DEC_UNROLL2_EN
  logic [3:0]       rnd_m1;
  logic [15:0][7:0] mid;
  // Rounds r and r-1 per cycle; r is always odd, so the first half always mixes.
  always_comb begin
    rnd_m1 = rnd_q - 4'd1;
    mid    = inv_round(blk_q, key_schedule[rnd_q], 1'b1);
  end
`endif

  // Next-state logic: load, round stepping and output handshake.
  always_comb begin
    st_d  = st_q;
    blk_d = blk_q;
    rnd_d = rnd_q;
    case (st_q)
      S_IDLE: if (in_valid) begin
        blk_d = in_data ^ key_schedule[10];
        rnd_d = 4'd9;
        st_d  = S_ROUND;
      end
      S_ROUND: begin
`ifdef AES_DEC_UNROLL2_EN
        blk_d = inv_round(mid, key_schedule[rnd_m1], rnd_m1 != 4'd0);
        if (rnd_q == 4'd1) begin
          rnd_d = 4'd0;
          st_d  = S_DONE;
        end else begin
          rnd_d = rnd_q - 4'd2;
        end
`else
        blk_d = inv_round(blk_q, key_schedule[rnd_q], rnd_q != 4'd0);
        if (rnd_q == 4'd0) st_d = S_DONE;
        else               rnd_d = rnd_q - 4'd1;
`endif
      end
      S_DONE: if (out_ready) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      blk_q <= '0;
      rnd_q <= 4'd0;
    end else begin
      st_q  <= st_d;
      blk_q <= blk_d;
      rnd_q <= rnd_d;
    end
  end

  assign in_ready  = (st_q == S_IDLE);
  assign out_valid = (st_q == S_DONE);
  assign out_data  = blk_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Scoreboard bench for aes_decrypt_core: a forward AES-128 model produces ciphertexts,
// and a monitor compares each plaintext, latency and accept interval.
module tb_aes_decrypt_core;
  typedef logic [15:0][7:0]  blk_t;
  typedef logic [10:0][127:0] ks_t;
  typedef struct { blk_t ct; ks_t ks; blk_t pt; bit has_pt; } exp_t;

`ifdef AES_DEC_UNROLL2_EN
  localparam int LAT = 5, MININT = 7;
`else
  localparam int LAT = 10, MININT = 12;
`endif

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  ks_t  key_schedule;
  blk_t in_data, out_data;

  aes_decrypt_core dut (
    .clk(clk), .rst_n(rst_n), .key_schedule(key_schedule), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   cyc = 0, last_acc = 0, n_acc = 0, n_sent = 0;
  bit   has_last = 0, b2b = 0, ov_prev = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // FIPS hex string (byte 0 leftmost) to bench byte order.
  function automatic blk_t h2b(input logic [127:0] h);
    blk_t b;
    for (int j = 0; j < 16; j++) b[j] = h[127-8*j -: 8];
    return b;
  endfunction

  function automatic ks_t expand(input blk_t key);
    ks_t ks; blk_t prev, cur; logic [7:0] rc;
    ks[0] = key; prev = key; rc = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      cur[0] = prev[0] ^ SBOX[prev[13]] ^ rc;
      cur[1] = prev[1] ^ SBOX[prev[14]];
      cur[2] = prev[2] ^ SBOX[prev[15]];
      cur[3] = prev[3] ^ SBOX[prev[12]];
      for (int j = 4; j < 16; j++) cur[j] = prev[j] ^ cur[j-4];
      ks[k] = cur; prev = cur; rc = xt(rc);
    end
    return ks;
  endfunction

  function automatic blk_t encrypt(input blk_t pt, input ks_t ks);
    blk_t s, t, u, v;
    s = pt ^ ks[0];
    for (int k = 1; k <= 10; k++) begin
      for (int i = 0; i < 16; i++) t[i] = SBOX[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) u[r+4*c] = t[r+4*((c+r)%4)];
      v = u;
      if (k < 10)
        for (int c = 0; c < 4; c++) begin
          v[4*c]   = xt(u[4*c]) ^ xt(u[4*c+1]) ^ u[4*c+1] ^ u[4*c+2] ^ u[4*c+3];
          v[4*c+1] = u[4*c] ^ xt(u[4*c+1]) ^ xt(u[4*c+2]) ^ u[4*c+2] ^ u[4*c+3];
          v[4*c+2] = u[4*c] ^ u[4*c+1] ^ xt(u[4*c+2]) ^ xt(u[4*c+3]) ^ u[4*c+3];
          v[4*c+3] = xt(u[4*c]) ^ u[4*c] ^ u[4*c+1] ^ u[4*c+2] ^ xt(u[4*c+3]);
        end
      s = v ^ ks[k];
    end
    return s;
  endfunction

  // Accept monitor: cycle count, accept count, accept-to-accept interval.
  initial forever begin
    @(posedge clk);
    if (!rst_n) has_last = 0;
    else if (in_valid && in_ready) begin
      if (has_last) begin
        if (b2b) chk("interval_b2b", 128'(cyc - last_acc), 128'(MININT));
        else     chk("interval_min", 128'(cyc - last_acc >= MININT), 128'd1);
      end
      last_acc = cyc; has_last = 1; n_acc++;
    end
    cyc++;
  end

  // Output monitor: pops the scoreboard on each new out_valid.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && !ov_prev) begin
      if (sb.size() == 0) chk("unexpected_output", 128'd1, 128'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        if (e.has_pt) chk("plaintext", out_data, e.pt);
        else          chk("reencrypt", encrypt(out_data, e.ks), e.ct);
        chk("latency", 128'(cyc - 1 - last_acc), 128'(LAT));
      end
    end
    ov_prev = rst_n && out_valid;
  end

  task automatic send(input blk_t ct, input ks_t ks, input blk_t pt, input bit has_pt);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 128'd0, 128'd1);
    e.ct = ct; e.ks = ks; e.pt = pt; e.has_pt = has_pt;
    sb.push_back(e);
    key_schedule = ks; in_data = ct; in_valid = 1'b1; n_sent++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    blk_t key, ct, pt, zero;
    ks_t  ks;
    int   n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; key_schedule = '0; out_ready = 1'b1;
    zero = '0;
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1
    key = h2b(128'h000102030405060708090a0b0c0d0e0f);
    ks  = expand(key);
    ct  = h2b(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    pt  = h2b(128'h00112233445566778899aabbccddeeff);
    send(ct, ks, pt, 1);
    drain();

    // Backpressure for three cycles after out_valid.
    out_ready = 1'b0;
    send(ct, ks, pt, 1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_data", out_data, pt);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);

    // Busy input: in_valid held with changing data while rounds run.
    send(ct, ks, pt, 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    chk("busy_accept_count", 128'(n_acc), 128'(n_sent));

    // Asynchronous reset in the middle of the rounds.
    send(ct, ks, pt, 1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_out_data", out_data, 128'd0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(ct, ks, pt, 1);
    drain();

    // All-zero key: zero ciphertext checked by re-encryption, known vector checked directly.
    ks = expand(zero);
    send(zero, ks, zero, 0);
    drain();
    send(h2b(128'h66e94bd4ef8a2c3b884cfa59ca342b2e), ks, zero, 1);
    drain();

    // Back-to-back random keys and plaintexts.
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      ks  = expand(key);
      send(encrypt(pt, ks), ks, pt, 1);
      b2b = 1;
    end
    drain();
    b2b = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
